bitslice_mem_ctrl: RTL

//  Upstream sequencer for a WIDTH-wide array of 4-word bitslices sharing rw/wordselect lines.

---
 rtl/bitslice_mem_ctrl_if.sv | 34 +++
 rtl/bitslice_mem_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bitslice_mem_ctrl_if.sv
// Handshake and slice-bus bundle for bitslice_mem_ctrl.
//   req_*  : request channel (valid/ready, write flag, word address, write data)
//   rsp_*  : single-cycle response (read data, write-verify error)
//   slice_*: shared rw / data / one-hot wordselect lines to the bitslice array,
//            plus the array's read output
// Modports:
//   master : the requester together with the bitslice array it fronts
//   slave  : the controller
interface bitslice_mem_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [1:0]       req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;
   logic             slice_rw;
   logic [WIDTH-1:0] slice_data;
   logic [3:0]       slice_ws;
   logic [WIDTH-1:0] slice_out;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, slice_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, slice_rw, slice_data, slice_ws
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, slice_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, slice_rw, slice_data, slice_ws
   );
endinterface

// File: rtl/bitslice_mem_ctrl.sv
// bitslice_mem_ctrl: sequencer for a WIDTH-wide array of 4-word bitslices that
// share rw / wordselect lines. One request at a time is accepted, then the slice
// lines are driven in SETUP -> STROBE -> HOLD order; reads capture the slice
// outputs and every transaction ends with a one-cycle response.
// Parameters:
//   WIDTH      : data bits (= number of bitslices)
//   STROBE_CYC : cycles wordselect stays high, must be >= 1
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : bitslice_mem_ctrl_if.slave (request, response, slice lines)
// Optional feature (macro BITSLICE_WRITE_VERIFY_EN):
//   writes are followed by a read-back pass; rsp_rdata carries the read-back
//   and rsp_err flags a mismatch against the written data. Without the macro
//   rsp_err is tied 0 and writes answer with rsp_rdata = 0.
module bitslice_mem_ctrl #(
   parameter int WIDTH      = 8,
   parameter int STROBE_CYC = 1
) (
   input  logic                clk,
   input  logic                rst,
   bitslice_mem_ctrl_if.slave  bus
);

   if (STROBE_CYC < 1) begin : g_bad_strobe_cyc
      $error("bitslice_mem_ctrl: STROBE_CYC must be >= 1");
   end

   localparam int CW = (STROBE_CYC < 1) ? 1 : $clog2(STROBE_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      CAPTURE,
      RESP
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             write_q;
   logic [1:0]       addr_q;
   logic             rw_q;
   logic [WIDTH-1:0] data_q;
   logic [3:0]       ws_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rdata_q;
`ifdef BITSLICE_WRITE_VERIFY_EN
   logic [WIDTH-1:0] wdata_q;
   logic             pass2_q;   // set while the read-back pass of a write runs
   logic             err_q;
`endif

   // All slice and response outputs are registered and set on the edge that
   // enters the state they belong to, so they are glitch-free and drop to 0
   // the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         data_q      <= '0;
         ws_q        <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
`ifdef BITSLICE_WRITE_VERIFY_EN
         wdata_q     <= '0;
         pass2_q     <= 1'b0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // req_ready is high throughout IDLE, so valid alone means accept
               if (bus.req_valid) begin
                  write_q <= bus.req_write;
                  addr_q  <= bus.req_addr;
                  rw_q    <= bus.req_write;
                  data_q  <= bus.req_write ? bus.req_wdata : '0;
`ifdef BITSLICE_WRITE_VERIFY_EN
                  wdata_q <= bus.req_wdata;
                  pass2_q <= 1'b0;
`endif
                  state   <= SETUP;
               end
            end

            SETUP: begin
               ws_q  <= 4'b0001 << addr_q;
               cnt   <= CW'(STROBE_CYC - 1);
               state <= STROBE;
            end

            STROBE: begin
               if (cnt == '0) begin
                  ws_q  <= '0;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            HOLD: begin
               // rw/data go back to 0; a read-back SETUP also wants rw=0, data=0
               rw_q   <= 1'b0;
               data_q <= '0;
               if (!write_q) begin
                  state <= CAPTURE;
`ifdef BITSLICE_WRITE_VERIFY_EN
               end else if (!pass2_q) begin
                  pass2_q <= 1'b1;
                  state   <= SETUP;
               end else begin
                  state <= CAPTURE;
               end
`else
               end else begin
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= '0;
                  state       <= RESP;
               end
`endif
            end

            CAPTURE: begin
               // slice outputs were latched by the slices during the strobe
               rsp_valid_q <= 1'b1;
               rdata_q     <= bus.slice_out;
`ifdef BITSLICE_WRITE_VERIFY_EN
               err_q       <= write_q && (bus.slice_out != wdata_q);
`endif
               state       <= RESP;
            end

            RESP: begin
               rsp_valid_q <= 1'b0;
               rdata_q     <= '0;
`ifdef BITSLICE_WRITE_VERIFY_EN
               err_q       <= 1'b0;
               pass2_q     <= 1'b0;
`endif
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rdata_q;
   assign bus.slice_rw   = rw_q;
   assign bus.slice_data = data_q;
   assign bus.slice_ws   = ws_q;
`ifdef BITSLICE_WRITE_VERIFY_EN
   assign bus.rsp_err    = err_q;
`else
   assign bus.rsp_err    = 1'b0;
`endif

endmodule
